cache_cpu_ctrl: RTL and testbench
=================================

Name: cache_cpu_ctrl

Overview:
- Processor-side MSI coherence controller for one private, direct-mapped cache.
- Owns the per-line state, tag and data arrays and serves CPU read and write requests.
- On misses and upgrades it wins the shared bus and broadcasts readMiss, writeMiss or invalidate. These are the messages consumed by the bus-side snoop state machine in every other cache.
- Accepts line-state updates back from its own bus-side snoop state machine, and writes back dirty victims to memory.

Parameters:
NUM_LINES, 4, number of cache lines (power of two); IDX_W = log2(NUM_LINES)
ADDR_W, 6, CPU word address width; index = addr[IDX_W-1:0], tag = addr[ADDR_W-1:IDX_W]
DATA_W, 8, data word width (one word per line)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  request strobe, sampled only in IDLE
cpu_write  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  request address
cpu_wdata  in  DATA_W  write data
cpu_ready  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid while cpu_ready = 1
bus_req  out  1  bus request, held high until bus_grant
bus_grant  in  1  bus granted
bus_msg_valid  out  1  one-cycle broadcast strobe
bus_readMiss  out  1  message type; one-hot, qualified by bus_msg_valid
bus_writeMiss  out  1  message type; one-hot, qualified by bus_msg_valid
bus_invalidate  out  1  message type; one-hot, qualified by bus_msg_valid
bus_addr  out  ADDR_W  address of the broadcast message
mem_wb_valid  out  1  one-cycle victim writeback strobe
mem_wb_addr  out  ADDR_W  victim address {victim_tag, index}
mem_wb_data  out  DATA_W  victim data
mem_rd_valid  in  1  fill data valid
mem_rd_data  in  DATA_W  fill data
snoop_valid  in  1  state update from the bus-side FSM
snoop_index  in  IDX_W  line being updated
snoop_state  in  2  new state: 00 Invalid, 01 Shared, 10 Modified
snoop_wb_data  out  DATA_W  combinational data[snoop_index], used for snoop writeback

Behaviour:
- Line state encoding: 00 Invalid, 01 Shared, 10 Modified. Encoding 11 is never written.
- Reset (asynchronous):
  - All line states Invalid; all tags and data 0.
  - FSM to IDLE.
  - All outputs 0, except snoop_wb_data, which stays combinational.
- FSM states: IDLE, LOOKUP, WB, ARB, MSG, FILL, DONE.
- IDLE:
  - If cpu_req = 1, latch cpu_write, cpu_addr and cpu_wdata, then go to LOOKUP.
  - The CPU must hold off further requests until cpu_ready.
- LOOKUP: hit = (state != Invalid) and (tag match).
  - Read hit: go to DONE; cpu_rdata = line data.
  - Write hit, Modified: write data, go to DONE.
  - Write hit, Shared: go to ARB (upgrade).
  - Miss, victim Modified: go to WB.
  - Miss, victim Invalid or Shared: go to ARB. A Shared victim is dropped silently.
- WB:
  - mem_wb_valid = 1 for exactly one cycle with victim addr/data.
  - Victim state goes to Invalid; next state ARB.
- ARB: bus_req = 1 until the cycle bus_grant = 1 is seen, then go to MSG. No timeout.
- MSG:
  - bus_req stays 1; bus_msg_valid = 1 for one cycle; bus_addr = latched address.
  - The message type is re-evaluated here against the current line state:
    - Write, line still Shared with matching tag: invalidate. Write data, state Modified, go to DONE (no fill).
    - Write, otherwise (includes an upgrade whose line was snooped Invalid while waiting): writeMiss, go to FILL.
    - Read: readMiss, go to FILL.
  - bus_req drops on leaving MSG.
- FILL:
  - Wait for mem_rd_valid; no timeout.
  - Read: data = mem_rd_data, state Shared, tag updated.
  - Write: data = latched cpu_wdata (whole-word write-allocate), fill data discarded, state Modified.
  - Then go to DONE.
- DONE: cpu_ready = 1 for one cycle, then go to IDLE.
- Latency from the cpu_req edge:
  - Read hit: cpu_ready in cycle 3.
  - Write hit Modified: cpu_ready in cycle 3.
  - Upgrade with immediate grant: cpu_ready in cycle 5.
- Snoop updates:
  - snoop_valid writes state[snoop_index] = snoop_state on the clock edge, in any FSM state.
  - If the controller writes the same index in the same cycle, the controller's write wins.
  - The controller never broadcasts to itself; no snoop of its own message.
- Reset mid-operation: transaction dropped, no cpu_ready, bus_req and strobes forced to 0 immediately.

Test Plan:
- Reset, then read addr 0x05 -> readMiss broadcast with bus_addr=0x05; mem_rd_data=0x3C; cpu_ready with cpu_rdata=0x3C; line 1 Shared.
- Read 0x05 again -> no bus_req; cpu_ready in cycle 3; cpu_rdata=0x3C.
- Write 0x05 data 0xA7 (line Shared), grant immediately -> bus_invalidate pulse, no FILL, line 1 Modified, later read returns 0xA7.
- Write 0x09 (same index 1, different tag) with line 1 Modified -> mem_wb_valid with addr 0x05 data 0xA7, then writeMiss bus_addr=0x09; after fill, line Modified with data = cpu_wdata.
- Upgrade of a Shared line with bus_grant delayed 3 cycles, snoop_valid sets that index Invalid while in ARB -> message sent is writeMiss (not invalidate), FILL entered.
- Assert reset while in FILL -> all lines Invalid, bus_req=0, no cpu_ready; the next request behaves as from cold.

Source files
------------

// File: rtl/cache_cpu_ctrl.sv
// cache_cpu_ctrl: CPU-side MSI controller for a private direct-mapped cache.
// Serves CPU requests, broadcasts misses/upgrades, writes back dirty victims.
module cache_cpu_ctrl #(
  parameter int NUM_LINES = 4,
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 8,
  parameter int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic              bus_msg_valid,
  output logic              bus_readMiss,
  output logic              bus_writeMiss,
  output logic              bus_invalidate,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              mem_wb_valid,
  output logic [ADDR_W-1:0] mem_wb_addr,
  output logic [DATA_W-1:0] mem_wb_data,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              snoop_valid,
  input  logic [IDX_W-1:0]  snoop_index,
  input  logic [1:0]        snoop_state,
  output logic [DATA_W-1:0] snoop_wb_data
);

  localparam int TAG_W = ADDR_W - IDX_W;

  localparam logic [1:0] INV = 2'b00;
  localparam logic [1:0] SHR = 2'b01;
  localparam logic [1:0] MOD = 2'b10;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOOKUP = 3'd1;
  localparam logic [2:0] WB     = 3'd2;
  localparam logic [2:0] ARB    = 3'd3;
  localparam logic [2:0] MSG    = 3'd4;
  localparam logic [2:0] FILL   = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  logic [2:0]        fsm;
  logic [2:0]        fsmNext;
  logic              reqWrite;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqWdata;

  logic [1:0]        lineState [NUM_LINES];
  logic [TAG_W-1:0]  lineTag   [NUM_LINES];
  logic [DATA_W-1:0] lineData  [NUM_LINES];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [1:0]        curState;
  logic              tagMatch;
  logic              hit;
  logic              upgrade;

  assign idx      = reqAddr[IDX_W-1:0];
  assign tag      = reqAddr[ADDR_W-1:IDX_W];
  assign curState = lineState[idx];
  assign tagMatch = lineTag[idx] == tag;
  assign hit      = (curState != INV) && tagMatch;
  // An upgrade stays an invalidate only if no snoop took the line away.
  assign upgrade  = reqWrite && (curState == SHR) && tagMatch;

  // Controller state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) fsm <= IDLE;
    else       fsm <= fsmNext;
  end

  // Next-state selection.
  always_comb begin
    fsmNext = fsm;
    unique case (fsm)
      IDLE:   if (cpu_req) fsmNext = LOOKUP;
      LOOKUP: begin
        if (hit && (!reqWrite || curState == MOD)) fsmNext = DONE;
        else if (!hit && curState == MOD)          fsmNext = WB;
        else                                       fsmNext = ARB;
      end
      WB:     fsmNext = ARB;
      ARB:    if (bus_grant) fsmNext = MSG;
      MSG:    fsmNext = upgrade ? DONE : FILL;
      FILL:   if (mem_rd_valid) fsmNext = DONE;
      DONE:   fsmNext = IDLE;
      default: fsmNext = IDLE;
    endcase
  end

  // Capture the CPU request when accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reqWrite <= 1'b0;
      reqAddr  <= '0;
      reqWdata <= '0;
    end else if (fsm == IDLE && cpu_req) begin
      reqWrite <= cpu_write;
      reqAddr  <= cpu_addr;
      reqWdata <= cpu_wdata;
    end
  end

  // Line arrays; controller writes are ordered after snoop writes so they win.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        lineState[i] <= INV;
        lineTag[i]   <= '0;
        lineData[i]  <= '0;
      end
    end else begin
      if (snoop_valid) lineState[snoop_index] <= snoop_state;
      unique case (fsm)
        LOOKUP: begin
          if (reqWrite && hit && curState == MOD) lineData[idx] <= reqWdata;
        end
        WB: lineState[idx] <= INV;
        MSG: begin
          if (upgrade) begin
            lineData[idx]  <= reqWdata;
            lineState[idx] <= MOD;
          end
        end
        FILL: begin
          if (mem_rd_valid) begin
            lineTag[idx] <= tag;
            if (reqWrite) begin
              lineData[idx]  <= reqWdata;
              lineState[idx] <= MOD;
            end else begin
              lineData[idx]  <= mem_rd_data;
              lineState[idx] <= SHR;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_ready      = fsm == DONE;
  assign cpu_rdata      = (fsm == DONE) ? lineData[idx] : '0;
  assign bus_req        = (fsm == ARB) || (fsm == MSG);
  assign bus_msg_valid  = fsm == MSG;
  assign bus_invalidate = (fsm == MSG) && upgrade;
  assign bus_writeMiss  = (fsm == MSG) && reqWrite && !upgrade;
  assign bus_readMiss   = (fsm == MSG) && !reqWrite;
  assign bus_addr       = (fsm == MSG) ? reqAddr : '0;
  assign mem_wb_valid   = fsm == WB;
  assign mem_wb_addr    = (fsm == WB) ? {lineTag[idx], idx} : '0;
  assign mem_wb_data    = (fsm == WB) ? lineData[idx] : '0;
  assign snoop_wb_data  = lineData[snoop_index];

endmodule

// File: tb/tb_cache_cpu_ctrl.sv
// tb_cache_cpu_ctrl: table vectors, randomized ops vs a line/memory model,
// and a reset-during-fill sequence for cache_cpu_ctrl.
module tb_cache_cpu_ctrl;

  logic       clock = 0;
  logic       reset = 1;
  logic       cpu_req = 0;
  logic       cpu_write = 0;
  logic [5:0] cpu_addr = 0;
  logic [7:0] cpu_wdata = 0;
  logic       cpu_ready;
  logic [7:0] cpu_rdata;
  logic       bus_req;
  logic       bus_grant = 0;
  logic       bus_msg_valid;
  logic       bus_readMiss;
  logic       bus_writeMiss;
  logic       bus_invalidate;
  logic [5:0] bus_addr;
  logic       mem_wb_valid;
  logic [5:0] mem_wb_addr;
  logic [7:0] mem_wb_data;
  logic       mem_rd_valid = 0;
  logic [7:0] mem_rd_data = 0;
  logic       snoop_valid = 0;
  logic [1:0] snoop_index = 0;
  logic [1:0] snoop_state = 0;
  logic [7:0] snoop_wb_data;

  cache_cpu_ctrl dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .bus_req(bus_req), .bus_grant(bus_grant),
    .bus_msg_valid(bus_msg_valid),
    .bus_readMiss(bus_readMiss),
    .bus_writeMiss(bus_writeMiss),
    .bus_invalidate(bus_invalidate),
    .bus_addr(bus_addr),
    .mem_wb_valid(mem_wb_valid),
    .mem_wb_addr(mem_wb_addr),
    .mem_wb_data(mem_wb_data),
    .mem_rd_valid(mem_rd_valid),
    .mem_rd_data(mem_rd_data),
    .snoop_valid(snoop_valid),
    .snoop_index(snoop_index),
    .snoop_state(snoop_state),
    .snoop_wb_data(snoop_wb_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         lat;
    logic [2:0] msg;
    int         nMsg;
    logic [5:0] msgAddr;
    int         nWb;
    logic [5:0] wbAddr;
    logic [7:0] wbData;
    logic [7:0] rdata;
  } obs_t;

  typedef struct {
    logic       wr;
    logic [5:0] addr;
    logic [7:0] wd;
    int         g;
    int         f;
    logic       kill;
    logic [7:0] fd;
    int         lat;
    logic [2:0] msg;
    logic [5:0] msgAddr;
    int         nWb;
    logic [5:0] wbAddr;
    logic [7:0] wbData;
    logic [7:0] rdata;
  } vec_t;

  int nVec = 0;
  int nBad = 0;

  logic [1:0] mSt   [4];
  logic [3:0] mTag  [4];
  logic [7:0] mData [4];
  logic [7:0] mem   [64];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: apply the MSI rules to whole-line records and a flat memory.
  task automatic predict(input logic wr, input logic [5:0] a,
                         input logic [7:0] wd, input int g, input int f,
                         input logic kill, output obs_t e);
    logic [1:0] i;
    logic [3:0] t;
    logic       h;
    int         wb;
    e = '{default: 0};
    i = a[1:0];
    t = a[5:2];
    h = (mSt[i] != 2'd0) && (mTag[i] == t);
    e.lat = 3;
    if (h && !wr) begin
      e.rdata = mData[i];
    end else if (h && mSt[i] == 2'd2) begin
      mData[i] = wd;
    end else begin
      wb = 0;
      if (!h && mSt[i] == 2'd2) begin
        wb = 1;
        e.nWb = 1;
        e.wbAddr = {mTag[i], i};
        e.wbData = mData[i];
        mem[e.wbAddr] = mData[i];
        mSt[i] = 2'd0;
      end
      if (kill) mSt[i] = 2'd0;
      e.nMsg = 1;
      e.msgAddr = a;
      if (wr && mSt[i] == 2'd1 && mTag[i] == t) begin
        e.msg = 3'b001;
        e.lat = g + 5;
        mData[i] = wd;
        mSt[i] = 2'd2;
      end else begin
        e.msg = wr ? 3'b010 : 3'b100;
        e.lat = g + f + 6 + wb;
        mTag[i] = t;
        if (wr) begin
          mData[i] = wd;
          mSt[i] = 2'd2;
        end else begin
          mData[i] = mem[a];
          mSt[i] = 2'd1;
          e.rdata = mem[a];
        end
      end
    end
  endtask

  // Drive one CPU transaction, acting as arbiter, memory and snooper.
  task automatic runOp(input logic wr, input logic [5:0] a,
                       input logic [7:0] wd, input int g, input int f,
                       input logic kill, input logic [7:0] fd,
                       output obs_t o);
    int   cyc;
    int   arbCnt;
    int   fillCnt;
    logic inFill;
    o = '{default: 0};
    arbCnt = 0;
    fillCnt = 0;
    inFill = 0;
    cpu_req = 1;
    cpu_write = wr;
    cpu_addr = a;
    cpu_wdata = wd;
    @(negedge clock);
    cyc = 2;
    cpu_req = 0;
    cpu_write = 0;
    cpu_addr = 0;
    cpu_wdata = 0;
    while (!cpu_ready && cyc < 200) begin
      bus_grant = 0;
      mem_rd_valid = 0;
      mem_rd_data = 0;
      snoop_valid = 0;
      if (mem_wb_valid) begin
        o.nWb++;
        o.wbAddr = mem_wb_addr;
        o.wbData = mem_wb_data;
      end
      if (bus_msg_valid) begin
        o.nMsg++;
        o.msg = {bus_readMiss, bus_writeMiss, bus_invalidate};
        o.msgAddr = bus_addr;
        if (!bus_invalidate) inFill = 1;
      end else if (inFill) begin
        if (fillCnt == f) begin
          mem_rd_valid = 1;
          mem_rd_data = fd;
        end
        fillCnt++;
      end else if (bus_req) begin
        if (kill && arbCnt == 0) begin
          snoop_valid = 1;
          snoop_index = a[1:0];
          snoop_state = 2'd0;
        end
        if (arbCnt == g) bus_grant = 1;
        arbCnt++;
      end
      @(negedge clock);
      cyc++;
    end
    o.lat = cyc;
    o.rdata = cpu_rdata;
    bus_grant = 0;
    mem_rd_valid = 0;
    mem_rd_data = 0;
    snoop_valid = 0;
    @(negedge clock);
  endtask

  task automatic cmpObs(input string nm, input logic wr,
                        input obs_t o, input obs_t e);
    chk({nm, " latency"}, o.lat, e.lat);
    chk({nm, " msgCount"}, o.nMsg, e.nMsg);
    chk({nm, " msgType"}, {29'd0, o.msg}, {29'd0, e.msg});
    if (e.nMsg != 0) chk({nm, " busAddr"}, {26'd0, o.msgAddr}, {26'd0, e.msgAddr});
    chk({nm, " wbCount"}, o.nWb, e.nWb);
    if (e.nWb != 0) begin
      chk({nm, " wbAddr"}, {26'd0, o.wbAddr}, {26'd0, e.wbAddr});
      chk({nm, " wbData"}, {24'd0, o.wbData}, {24'd0, e.wbData});
    end
    if (!wr) chk({nm, " rdata"}, {24'd0, o.rdata}, {24'd0, e.rdata});
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      mSt[i] = 0;
      mTag[i] = 0;
      mData[i] = 0;
    end
  endtask

  vec_t tbl [16];
  obs_t o;
  obs_t e;
  obs_t te;

  initial begin
    tbl[0]  = '{0, 6'h05, 8'h00, 0, 0, 0, 8'h3C, 6,  3'b100, 6'h05, 0, 6'h00, 8'h00, 8'h3C};
    tbl[1]  = '{0, 6'h05, 8'h00, 0, 0, 0, 8'h00, 3,  3'b000, 6'h00, 0, 6'h00, 8'h00, 8'h3C};
    tbl[2]  = '{1, 6'h05, 8'hA7, 0, 0, 0, 8'h00, 5,  3'b001, 6'h05, 0, 6'h00, 8'h00, 8'h00};
    tbl[3]  = '{0, 6'h05, 8'h00, 0, 0, 0, 8'h00, 3,  3'b000, 6'h00, 0, 6'h00, 8'h00, 8'hA7};
    tbl[4]  = '{1, 6'h09, 8'h5E, 0, 0, 0, 8'h77, 7,  3'b010, 6'h09, 1, 6'h05, 8'hA7, 8'h00};
    tbl[5]  = '{0, 6'h09, 8'h00, 0, 0, 0, 8'h00, 3,  3'b000, 6'h00, 0, 6'h00, 8'h00, 8'h5E};
    tbl[6]  = '{0, 6'h0A, 8'h00, 2, 3, 0, 8'h11, 11, 3'b100, 6'h0A, 0, 6'h00, 8'h00, 8'h11};
    tbl[7]  = '{1, 6'h0A, 8'h22, 3, 1, 1, 8'h99, 10, 3'b010, 6'h0A, 0, 6'h00, 8'h00, 8'h00};
    tbl[8]  = '{0, 6'h0A, 8'h00, 0, 0, 0, 8'h00, 3,  3'b000, 6'h00, 0, 6'h00, 8'h00, 8'h22};
    tbl[9]  = '{1, 6'h09, 8'h33, 0, 0, 0, 8'h00, 3,  3'b000, 6'h00, 0, 6'h00, 8'h00, 8'h00};
    tbl[10] = '{0, 6'h09, 8'h00, 0, 0, 0, 8'h00, 3,  3'b000, 6'h00, 0, 6'h00, 8'h00, 8'h33};
    tbl[11] = '{0, 6'h0D, 8'h00, 1, 0, 0, 8'h44, 8,  3'b100, 6'h0D, 1, 6'h09, 8'h33, 8'h44};
    tbl[12] = '{1, 6'h03, 8'h55, 0, 2, 0, 8'h00, 8,  3'b010, 6'h03, 0, 6'h00, 8'h00, 8'h00};
    tbl[13] = '{0, 6'h0D, 8'h00, 0, 0, 0, 8'h00, 3,  3'b000, 6'h00, 0, 6'h00, 8'h00, 8'h44};
    tbl[14] = '{1, 6'h11, 8'h66, 0, 0, 0, 8'h00, 6,  3'b010, 6'h11, 0, 6'h00, 8'h00, 8'h00};
    tbl[15] = '{0, 6'h11, 8'h00, 0, 0, 0, 8'h00, 3,  3'b000, 6'h00, 0, 6'h00, 8'h00, 8'h66};

    modelReset();
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);

    #1;
    chk("resetOutputs",
        {20'd0, cpu_ready, bus_req, bus_msg_valid, bus_readMiss,
         bus_writeMiss, bus_invalidate, mem_wb_valid, cpu_rdata != 0,
         bus_addr != 0, mem_wb_addr != 0, mem_wb_data != 0, 1'b0},
        32'd0);
    for (int i = 0; i < 4; i++) begin
      snoop_index = 2'(i);
      #1;
      chk("resetData", {24'd0, snoop_wb_data}, 32'd0);
    end
    snoop_index = 0;
    @(negedge clock);
    reset = 0;
    @(negedge clock);

    for (int k = 0; k < 16; k++) begin
      if (!tbl[k].wr) mem[tbl[k].addr] = tbl[k].fd;
      predict(tbl[k].wr, tbl[k].addr, tbl[k].wd, tbl[k].g, tbl[k].f,
              tbl[k].kill, e);
      runOp(tbl[k].wr, tbl[k].addr, tbl[k].wd, tbl[k].g, tbl[k].f,
            tbl[k].kill, tbl[k].fd, o);
      te = '{default: 0};
      te.lat = tbl[k].lat;
      te.msg = tbl[k].msg;
      te.nMsg = (tbl[k].msg != 0) ? 1 : 0;
      te.msgAddr = tbl[k].msgAddr;
      te.nWb = tbl[k].nWb;
      te.wbAddr = tbl[k].wbAddr;
      te.wbData = tbl[k].wbData;
      te.rdata = tbl[k].rdata;
      cmpObs($sformatf("vec%0d", k), tbl[k].wr, o, te);
    end

    for (int k = 0; k < 60; k++) begin
      logic       wr;
      logic [5:0] a;
      logic [7:0] wd;
      int         g;
      int         f;
      logic       kill;
      wr = 1'($urandom_range(0, 1));
      a = 6'($urandom_range(0, 15));
      wd = 8'($urandom);
      g = $urandom_range(0, 3);
      f = $urandom_range(0, 3);
      kill = $urandom_range(0, 4) == 0;
      predict(wr, a, wd, g, f, kill, e);
      runOp(wr, a, wd, g, f, kill, mem[a], o);
      cmpObs($sformatf("rnd%0d", k), wr, o, e);
      if ($urandom_range(0, 9) < 3) begin
        logic [1:0] si;
        logic [1:0] ss;
        si = 2'($urandom_range(0, 3));
        ss = 2'($urandom_range(0, 2));
        snoop_valid = 1;
        snoop_index = si;
        snoop_state = ss;
        #1;
        chk("snoopWbData", {24'd0, snoop_wb_data}, {24'd0, mData[si]});
        mSt[si] = ss;
        @(negedge clock);
        snoop_valid = 0;
      end
    end

    begin
      int   n;
      logic sawReady;
      cpu_req = 1;
      cpu_write = 0;
      cpu_addr = 6'h21;
      @(negedge clock);
      cpu_req = 0;
      n = 0;
      while (!bus_msg_valid && n < 20) begin
        bus_grant = bus_req;
        @(negedge clock);
        n++;
      end
      bus_grant = 0;
      chk("rstSeqMsg", {31'd0, bus_msg_valid}, 32'd1);
      @(negedge clock);
      @(negedge clock);
      chk("fillBusReqLow", {31'd0, bus_req}, 32'd0);
      #2;
      reset = 1;
      #1;
      chk("rstMidOutputs",
          {29'd0, bus_req, cpu_ready, bus_msg_valid}, 32'd0);
      @(negedge clock);
      reset = 0;
      modelReset();
      sawReady = 0;
      for (int c = 0; c < 4; c++) begin
        mem_rd_valid = 1;
        mem_rd_data = 8'h5A;
        @(negedge clock);
        if (cpu_ready) sawReady = 1;
      end
      mem_rd_valid = 0;
      mem_rd_data = 0;
      chk("rstNoReady", {31'd0, sawReady}, 32'd0);
      for (int i = 0; i < 4; i++) begin
        snoop_index = 2'(i);
        #1;
        chk("rstDataClr", {24'd0, snoop_wb_data}, 32'd0);
      end
      snoop_index = 0;
      @(negedge clock);
      mem[6'h05] = 8'h3C;
      predict(0, 6'h05, 8'h00, 0, 0, 0, e);
      runOp(0, 6'h05, 8'h00, 0, 0, 0, mem[6'h05], o);
      cmpObs("cold", 1'b0, o, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
